// File: rtl/extend_unit.sv
// Registered 16-to-32-bit immediate extender (zero/sign), one-cycle latency.
// Optional 8-bit source mode is compiled in when EXTEND_BYTE_EN is defined.
module extend_unit #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  a,
  input  logic             sext,
  input  logic             byte_sel,
  output logic [OUT_W-1:0] b,
  output logic             out_valid,
  output logic             neg
);

  // Handshake: valid-only, no ready. Every cycle with in_valid=1 is accepted;
  // out_valid is in_valid delayed one edge, while b/neg hold between samples.

  logic [OUT_W-1:0] ext;

`ifdef EXTEND_BYTE_EN
  always_comb begin
    ext = '0;
    if (byte_sel) begin
      ext = {{24{sext & a[7]}}, a[7:0]};
    end else begin
      ext = {{16{sext & a[15]}}, a[15:0]};
    end
  end
`else
  logic unused_byte_sel;
  assign unused_byte_sel = byte_sel;

  always_comb begin
    ext = {{16{sext & a[15]}}, a[15:0]};
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b         <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        b   <= ext;
        neg <= ext[OUT_W-1];
      end
    end
  end

endmodule

// File: tb/tb_extend_unit.sv
// Self-checking bench for extend_unit: directed cases plus random samples
// against an arithmetic reference model and an expected-result queue.
module tb_extend_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic        sext;
  logic        byte_sel;
  logic [31:0] b;
  logic        out_valid;
  logic        neg;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  logic [31:0] last_b;

  extend_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .sext      (sext),
    .byte_sel  (byte_sel),
    .b         (b),
    .out_valid (out_valid),
    .neg       (neg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && in_valid) begin
      assert (!$isunknown({sext, byte_sel}))
        else $error("illegal X on sext/byte_sel while in_valid");
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: take the low w bits as an unsigned number; when signed and the
  // top bit of that field is set, the value is field - 2^w, wrapped to 32 bits.
  function automatic logic [31:0] ref_ext(input logic [15:0] av, input logic s, input logic bs);
    longint w;
    longint field;
    longint v;
    w = 16;
`ifdef EXTEND_BYTE_EN
    if (bs) w = 8;
`endif
    field = longint'(av) % (longint'(1) << w);
    v = field;
    if (s && field >= (longint'(1) << (w - 1))) v = field - (longint'(1) << w);
    return 32'(v);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    last_b = 32'h0;
  endtask

  // Drive one cycle, then check outputs #1 after the edge.
  task automatic step(input logic v, input logic [15:0] av, input logic s, input logic bs);
    logic [31:0] e;
    in_valid = v;
    a        = av;
    sext     = s;
    byte_sel = bs;
    if (v) exp_q.push_back(ref_ext(av, s, bs));
    @(posedge clk);
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, v});
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'h1, 32'h0);
      end else begin
        e = exp_q.pop_front();
        last_b = e;
      end
    end
    check("b", b, last_b);
    check("neg", {31'b0, neg}, {31'b0, (last_b >= 32'h8000_0000)});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_b"}, b, 32'h0);
    check({tag, "_neg"}, {31'b0, neg}, 32'h0);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'h0);
  endtask

  initial begin
    // reset with arbitrary inputs
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 16'hbeef;
    sext     = 1'b1;
    byte_sel = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("reset_async");
    @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst = 1'b0;

    // first edge after release is a normal sample
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    check("release_zero", b, 32'h0000_0000);

    step(1'b1, 16'h0000, 1'b1, 1'b0);
    check("zero_sext", b, 32'h0000_0000);
    step(1'b1, 16'h0000, 1'b0, 1'b0);
    check("zero_zext", b, 32'h0000_0000);

    step(1'b1, 16'h8000, 1'b0, 1'b0);
    check("msb_zext", b, 32'h0000_8000);
    check("msb_zext_neg", {31'b0, neg}, 32'h0);
    step(1'b1, 16'h8000, 1'b1, 1'b0);
    check("msb_sext", b, 32'hFFFF_8000);
    check("msb_sext_neg", {31'b0, neg}, 32'h1);

    step(1'b1, 16'hFFFF, 1'b0, 1'b0);
    check("ones_zext", b, 32'h0000_FFFF);
    step(1'b1, 16'hFFFF, 1'b1, 1'b0);
    check("ones_sext", b, 32'hFFFF_FFFF);
    check("ones_sext_neg", {31'b0, neg}, 32'h1);

    // hold while idle
    step(1'b1, 16'h8000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 16'h1234, i[0], 1'b0);
      check("hold_b", b, 32'hFFFF_8000);
    end

    // byte mode
    step(1'b1, 16'h1280, 1'b1, 1'b1);
`ifdef EXTEND_BYTE_EN
    check("byte_sext", b, 32'hFFFF_FF80);
`else
    check("byte_ignored", b, 32'h0000_1280);
`endif
    step(1'b1, 16'h1280, 1'b0, 1'b1);
`ifdef EXTEND_BYTE_EN
    check("byte_zext", b, 32'h0000_0080);
`else
    check("byte_ignored_z", b, 32'h0000_1280);
`endif

    // mid-stream reset discards the pending sample, asynchronously
    in_valid = 1'b1;
    a        = 16'hC001;
    sext     = 1'b1;
    byte_sel = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_mid");
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("reset_mid_held");
    rst = 1'b0;

    // randomized mix of valid/idle, modes and operands
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 3) != 0), 16'($urandom_range(0, 65535)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    step(1'b0, 16'h0, 1'b0, 1'b0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
